cnn_mac_pipe: RTL

CNN_MAC_PIPE -- requirements
Module: cnn_mac_pipe

---
 rtl/cnn_mac_pipe_if.sv | 14 +
 rtl/cnn_mac_pipe.sv | 69 ++++++
 2 files changed

// File: rtl/cnn_mac_pipe_if.sv
// cnn_mac_pipe_if: operand/result bus for cnn_mac_pipe
// master drives in_valid/din0/din1/first/last/mode and receives out_valid/dout/sat; slave is the MAC side
interface cnn_mac_pipe_if #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 10,
  parameter int ACC_WIDTH  = 32
);
  logic in_valid, first, last, mode, out_valid, sat;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic signed [ACC_WIDTH-1:0] dout;
  modport master(output in_valid, din0, din1, first, last, mode, input out_valid, dout, sat);
  modport slave(input in_valid, din0, din1, first, last, mode, output out_valid, dout, sat);
endinterface

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed multiplier with saturating accumulate stage
// clk/reset (async, active-high), ce freezes all state; bus carries operands with first/last/mode in, out_valid/dout/sat out
module cnn_mac_pipe #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 10,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STAGE  = 3
) (
  input logic clk,
  input logic reset,
  input logic ce,
  cnn_mac_pipe_if.slave bus
);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic signed [PW-1:0] mul;
  logic signed [ACC_WIDTH-1:0] prod_q [NUM_STAGE];
  logic signed [ACC_WIDTH-1:0] prod_d [NUM_STAGE];
  logic [3:0] side_q [NUM_STAGE];
  logic [3:0] side_d [NUM_STAGE];
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, dout_q, dout_d, p, base;
  logic [ACC_WIDTH:0] sum;
  logic flag_q, flag_d, out_valid_q, out_valid_d, sat_q, sat_d;
  logic v, f, l, m, ovf, mac;
  assign mul = bus.din0 * bus.din1;
  always_comb begin
    prod_d[0] = ACC_WIDTH'(mul);
    side_d[0] = {bus.in_valid, bus.first, bus.last, bus.mode};
    for (int i = 1; i < NUM_STAGE; i++) begin
      prod_d[i] = prod_q[i-1];
      side_d[i] = side_q[i-1];
    end
    {v, f, l, m} = side_q[NUM_STAGE-1];
    p = prod_q[NUM_STAGE-1];
    base = f ? '0 : acc_q;
    // one guard bit: overflow shows up as the top two bits disagreeing
    sum = {base[ACC_WIDTH-1], base} + {p[ACC_WIDTH-1], p};
    ovf = sum[ACC_WIDTH] != sum[ACC_WIDTH-1];
    mac = v & m;
    acc_d = mac ? (ovf ? (sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX) : sum[ACC_WIDTH-1:0]) : acc_q;
    flag_d = mac ? ((~f & flag_q) | ovf) : flag_q;
    out_valid_d = v & (~m | l);
    dout_d = out_valid_d ? (m ? acc_d : p) : dout_q;
    sat_d = out_valid_d ? (m & flag_d) : sat_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= '{default: '0};
      side_q <= '{default: '0};
      acc_q <= '0;
      flag_q <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q <= '0;
      sat_q <= 1'b0;
    end else if (ce) begin
      prod_q <= prod_d;
      side_q <= side_d;
      acc_q <= acc_d;
      flag_q <= flag_d;
      out_valid_q <= out_valid_d;
      dout_q <= dout_d;
      sat_q <= sat_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.dout = dout_q;
  assign bus.sat = sat_q;
endmodule
